// File: rtl/axis_bram_reader.sv
// Streams a block of BRAM words (BRAM-major walk) out as AXI-Stream with TLAST on the final beat.
// Latency: start edge N -> first read strobe sampled N+1 -> first tvalid sampled N+3; 1 beat/cycle sustained.
// Backpressure: reads are gated on output FIFO space, so tready may stall indefinitely without loss.
module axis_bram_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int SEL_WIDTH  = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [SEL_WIDTH-1:0]  rd_bram_start,
    input  logic [SEL_WIDTH-1:0]  rd_bram_end,
    input  logic [CNT_WIDTH-1:0]  rd_addr_start,
    input  logic [CNT_WIDTH-1:0]  rd_addr_count,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_rd_en,
    output logic [ADDR_WIDTH-1:0] bram_rd_addr,
    output logic [SEL_WIDTH-1:0]  mux_sel,
    input  logic [DATA_WIDTH-1:0] bram_rd_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam int BEAT_W = CNT_WIDTH + SEL_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_end_q, mux_sel_q;
    logic [ADDR_WIDTH-1:0]   addr_base_q;
    logic [CNT_WIDTH-1:0]    cnt_q, idx_q;
    logic [BEAT_W-1:0]       beat_q, total_q;
    logic                    empty_q;
    logic                    rd_vld_q, rd_last_q;

    logic                    rd_en, pop, issue_ok, last_rd;
    logic [SEL_WIDTH:0]      span;
    logic [BEAT_W-1:0]       total_d;
    logic                    empty_d;
    logic [1:0]              fifo_occ;
    logic [DATA_WIDTH:0]     fifo_head;
    logic                    unused_addr_hi;

    assign unused_addr_hi = ^rd_addr_start[CNT_WIDTH-1:ADDR_WIDTH];

    assign span    = {1'b0, rd_bram_end} - {1'b0, rd_bram_start} + (SEL_WIDTH+1)'(1);
    assign total_d = BEAT_W'(rd_addr_count) * BEAT_W'(span);
    assign empty_d = (rd_addr_count == '0) || (rd_bram_end < rd_bram_start);

    assign pop     = m_axis_tvalid & m_axis_tready;
    // The read issued now lands in the FIFO next edge; the one returning now lands this edge.
    assign issue_ok = ({1'b0, fifo_occ} + {2'b00, rd_vld_q}) <= (3'd1 + {2'b00, pop});
    assign last_rd  = (beat_q == total_q - BEAT_W'(1));

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: begin
                if (empty_q) begin
                    state_d = S_DONE;
                end else if (issue_ok) begin
                    rd_en = 1'b1;
                    if (last_rd) state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (pop && m_axis_tlast) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            sel_end_q   <= '0;
            mux_sel_q   <= '0;
            addr_base_q <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            beat_q      <= '0;
            total_q     <= '0;
            empty_q     <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_vld_q  <= rd_en;
            rd_last_q <= rd_en & last_rd;
            if (rd_en) mux_sel_q <= sel_q;

            if (state_q == S_IDLE && start) begin
                sel_q       <= rd_bram_start;
                sel_end_q   <= rd_bram_end;
                addr_base_q <= rd_addr_start[ADDR_WIDTH-1:0];
                cnt_q       <= rd_addr_count;
                idx_q       <= '0;
                beat_q      <= '0;
                total_q     <= total_d;
                empty_q     <= empty_d;
            end else if (rd_en) begin
                beat_q <= beat_q + BEAT_W'(1);
                if (idx_q == cnt_q - CNT_WIDTH'(1)) begin
                    idx_q <= '0;
                    if (sel_q != sel_end_q) sel_q <= sel_q + SEL_WIDTH'(1);
                end else begin
                    idx_q <= idx_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    axis_bram_reader_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (2)
    ) u_out_fifo (
        .clk      (aclk),
        .rst      (areset),
        .push_vld (rd_vld_q),
        .push_dat ({rd_last_q, bram_rd_data}),
        .pop      (pop),
        .head_dat (fifo_head),
        .occ      (fifo_occ)
    );

    assign busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign bram_rd_en    = rd_en;
    assign bram_rd_addr  = addr_base_q + idx_q[ADDR_WIDTH-1:0];
    assign mux_sel       = mux_sel_q;
    assign m_axis_tvalid = (fifo_occ != 2'd0);
    assign m_axis_tdata  = fifo_head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = fifo_head[DATA_WIDTH];

endmodule

// Generic show-ahead FIFO: head_dat is the oldest entry whenever occ != 0.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module axis_bram_reader_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] occ
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({push_vld, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: tb/tb_axis_bram_reader.sv
// Directed bench for axis_bram_reader: BRAM model returns {sel,addr}, scoreboard checks every beat.
module tb_axis_bram_reader;

    logic        aclk = 1'b0;
    logic        areset, start;
    logic [2:0]  rd_bram_start, rd_bram_end;
    logic [15:0] rd_addr_start, rd_addr_count;
    logic        busy, done, bram_rd_en;
    logic [8:0]  bram_rd_addr;
    logic [2:0]  mux_sel;
    logic [15:0] bram_rd_data;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;

    always #5 aclk = ~aclk;

    axis_bram_reader dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .rd_bram_start (rd_bram_start),
        .rd_bram_end   (rd_bram_end),
        .rd_addr_start (rd_addr_start),
        .rd_addr_count (rd_addr_count),
        .busy          (busy),
        .done          (done),
        .bram_rd_en    (bram_rd_en),
        .bram_rd_addr  (bram_rd_addr),
        .mux_sel       (mux_sel),
        .bram_rd_data  (bram_rd_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    // BRAM bank model: address registered on the strobe, data tagged with the select steering it.
    logic [8:0] bram_addr_q = '0;
    always @(posedge aclk) if (bram_rd_en) bram_addr_q <= bram_rd_addr;
    assign bram_rd_data = {4'b0000, mux_sel, bram_addr_q};

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int rdy_mode = 0;
    logic [16:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ($urandom_range(0, 1) == 1);
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks stall stability and the done pulse.
    logic        stall_prev = 1'b0;
    logic [15:0] prev_dat = '0;
    logic        prev_last = 1'b0;
    int          done_chk = 0;
    always @(negedge aclk) begin
        logic [16:0] e;
        if (areset) begin
            stall_prev = 1'b0;
            done_chk   = 0;
        end else begin
            if (done_chk == 1) begin
                chk("done_pulse", 32'(done), 32'd1);
                done_chk = 2;
            end else if (done_chk == 2) begin
                chk("done_width", 32'(done), 32'd0);
                done_chk = 0;
            end
            if (stall_prev) begin
                chk("tvalid_hold", 32'(m_axis_tvalid), 32'd1);
                chk("tdata_hold", 32'(m_axis_tdata), 32'(prev_dat));
                chk("tlast_hold", 32'(m_axis_tlast), 32'(prev_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 32'(m_axis_tdata), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", 32'(m_axis_tdata), 32'(e[15:0]));
                    chk("tlast", 32'(m_axis_tlast), 32'(e[16]));
                    if (e[16]) done_chk = 1;
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_dat   = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic push_exp(input logic [15:0] dat, input logic last);
        exp_q.push_back({last, dat});
    endtask

    task automatic push_walk(input int bs, input int be, input int as, input int cnt);
        for (int s = bs; s <= be; s++)
            for (int i = 0; i < cnt; i++)
                push_exp({4'b0000, 3'(s), 9'((as + i) % 512)}, (s == be) && (i == cnt - 1));
    endtask

    task automatic pulse_start(input int bs, input int be, input int as, input int cnt);
        @(posedge aclk);
        #1;
        rd_bram_start = 3'(bs);
        rd_bram_end   = 3'(be);
        rd_addr_start = 16'(as);
        rd_addr_count = 16'(cnt);
        start         = 1'b1;
        @(posedge aclk);
        #1;
        start = 1'b0;
    endtask

    // k counts negedges after the start edge; -1 means never seen.
    task automatic watch(input int max, output int first_rd, output int first_v,
                         output int last_hs, output int done_at);
        first_rd = -1; first_v = -1; last_hs = -1; done_at = -1;
        for (int k = 1; k <= max; k++) begin
            @(negedge aclk);
            if (bram_rd_en && first_rd < 0) first_rd = k;
            if (m_axis_tvalid && first_v < 0) first_v = k;
            if (m_axis_tvalid && m_axis_tready) last_hs = k;
            if (done) begin
                done_at = k;
                break;
            end
        end
        if (done_at < 0) chk("done_timeout", 32'(done_at), 32'(max));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        chk({tag, "_tdata"},  32'(m_axis_tdata),  32'd0);
        chk({tag, "_tlast"},  32'(m_axis_tlast),  32'd0);
        chk({tag, "_busy"},   32'(busy),          32'd0);
        chk({tag, "_done"},   32'(done),          32'd0);
        chk({tag, "_rd_en"},  32'(bram_rd_en),    32'd0);
        chk({tag, "_addr"},   32'(bram_rd_addr),  32'd0);
        chk({tag, "_sel"},    32'(mux_sel),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int frd, fv, lhs, dat, hs0;
        areset = 1'b1; start = 1'b0;
        rd_bram_start = '0; rd_bram_end = '0; rd_addr_start = '0; rd_addr_count = '0;
        @(posedge aclk);
        @(negedge aclk);
        chk_all_zero("reset");
        @(posedge aclk);
        #1 areset = 1'b0;

        // 1: single BRAM, full rate, latency and done timing
        rdy_mode = 0;
        push_exp(16'h0010, 1'b0); push_exp(16'h0011, 1'b0);
        push_exp(16'h0012, 1'b0); push_exp(16'h0013, 1'b1);
        hs0 = hs_cnt;
        pulse_start(0, 0, 'h010, 4);
        watch(50, frd, fv, lhs, dat);
        chk("t1_first_rd", 32'(frd), 32'd1);
        chk("t1_first_valid", 32'(fv), 32'd3);
        chk("t1_last_hs", 32'(lhs), 32'd6);
        chk("t1_done_at", 32'(dat), 32'd7);
        chk("t1_beats", 32'(hs_cnt - hs0), 32'd4);

        // 2: BRAM 2..4, three words each
        push_walk(2, 4, 0, 3);
        hs0 = hs_cnt;
        pulse_start(2, 4, 0, 3);
        watch(80, frd, fv, lhs, dat);
        chk("t2_first_valid", 32'(fv), 32'd3);
        chk("t2_last_hs", 32'(lhs), 32'd11);
        chk("t2_beats", 32'(hs_cnt - hs0), 32'd9);
        chk("t2_queue", 32'(exp_q.size()), 32'd0);

        // 3: same transfer under random backpressure plus a long stall
        rdy_mode = 1;
        push_walk(2, 4, 0, 3);
        hs0 = hs_cnt;
        pulse_start(2, 4, 0, 3);
        repeat (4) @(negedge aclk);
        rdy_mode = 2;
        repeat (20) @(negedge aclk);
        chk("t3_stall_rd_en", 32'(bram_rd_en), 32'd0);
        chk("t3_stall_tvalid", 32'(m_axis_tvalid), 32'd1);
        rdy_mode = 1;
        watch(400, frd, fv, lhs, dat);
        chk("t3_beats", 32'(hs_cnt - hs0), 32'd9);
        chk("t3_queue", 32'(exp_q.size()), 32'd0);

        // 4: address wrap at the top of the BRAM
        rdy_mode = 0;
        push_exp(16'h03FE, 1'b0); push_exp(16'h03FF, 1'b0);
        push_exp(16'h0200, 1'b0); push_exp(16'h0201, 1'b1);
        hs0 = hs_cnt;
        pulse_start(1, 1, 'h1FE, 4);
        watch(50, frd, fv, lhs, dat);
        chk("t4_beats", 32'(hs_cnt - hs0), 32'd4);

        // 5: empty transfers, then a start while busy
        hs0 = hs_cnt;
        pulse_start(0, 0, 0, 0);
        watch(20, frd, fv, lhs, dat);
        chk("t5a_no_rd", 32'(frd), 32'hFFFF_FFFF);
        chk("t5a_no_valid", 32'(fv), 32'hFFFF_FFFF);
        chk("t5a_done_at", 32'(dat), 32'd2);
        pulse_start(5, 3, 0, 4);
        watch(20, frd, fv, lhs, dat);
        chk("t5b_no_valid", 32'(fv), 32'hFFFF_FFFF);
        chk("t5b_done_at", 32'(dat), 32'd2);
        chk("t5_empty_beats", 32'(hs_cnt - hs0), 32'd0);
        push_walk(0, 1, 'h20, 2);
        hs0 = hs_cnt;
        pulse_start(0, 1, 'h20, 2);
        pulse_start(3, 7, 'h40, 5);
        watch(50, frd, fv, lhs, dat);
        repeat (10) @(negedge aclk);
        chk("t5c_beats", 32'(hs_cnt - hs0), 32'd4);
        chk("t5c_idle_valid", 32'(m_axis_tvalid), 32'd0);
        chk("t5c_busy", 32'(busy), 32'd0);

        // 6: reset after three of eight beats, then a clean transfer
        push_walk(0, 1, 0, 4);
        hs0 = hs_cnt;
        pulse_start(0, 1, 0, 4);
        for (int k = 0; k < 50; k++) begin
            @(posedge aclk);
            if (hs_cnt - hs0 >= 3) break;
        end
        rdy_mode = 2;
        #1;
        areset = 1'b1;
        exp_q.delete();
        @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        chk_all_zero("t6_reset");
        chk("t6_partial_beats", 32'(hs_cnt - hs0), 32'd3);
        rdy_mode = 0;
        push_walk(0, 1, 0, 4);
        hs0 = hs_cnt;
        pulse_start(0, 1, 0, 4);
        watch(60, frd, fv, lhs, dat);
        chk("t6_beats", 32'(hs_cnt - hs0), 32'd8);
        chk("t6_queue", 32'(exp_q.size()), 32'd0);

        repeat (4) @(negedge aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
